pulse_measure: RTL

//  Downstream consumer of the posedge pulse generator. Measures each pulse on pulse_in in clk

---
 rtl/pulse_measure.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pulse_measure.sv
// pulse_measure: measures high width and rise-to-rise period of pulse_in in clk cycles.
// Results are published through a one-entry valid/ready holding register. Both counters
// saturate, and a per-measurement sat flag records any saturation. A sticky overrun flag
// records every result dropped because the register was still held.
// Optional build macro: PULSE_MEAS_SYNC_EN adds a 2-flop input synchronizer.
module pulse_measure #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pulse_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             sat,
    output logic             overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Saturating increment: returns {saturate_event, next_value}
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return {1'b1, v};
        end else begin
            return {1'b0, v + CNT_ONE};
        end
    endfunction

    logic             pulse_s;
    logic             edge_en_s;
    logic             pulse_d_r;
    logic             rise_s;
    logic             fall_s;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] hc_r, hc_s;
    logic [CNT_W-1:0] pc_r, pc_s;
    logic             msat_r, msat_s;
    logic             close_s;
    logic [CNT_W-1:0] h_inc_s, p_inc_s;
    logic             h_ov_s, p_ov_s;

`ifdef PULSE_MEAS_SYNC_EN
    logic [1:0] sync_r;
    logic [1:0] warm_r;

    // Two-flop synchronizer plus a warm-up shift that masks edges until the chain holds real data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
            warm_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pulse_in};
            warm_r <= {warm_r[0], 1'b1};
        end
    end

    assign pulse_s   = sync_r[1];
    // While the synchronizer is still filling, pulse_d is held at 1 so that a line already
    // high at reset release is not seen as a rising edge when it emerges from the chain.
    assign edge_en_s = warm_r[1];
`else
    assign pulse_s   = pulse_in;
    assign edge_en_s = 1'b1;
`endif

    assign rise_s = pulse_s & ~pulse_d_r;
    assign fall_s = ~pulse_s & pulse_d_r;
    assign {h_ov_s, h_inc_s} = sat_inc(hc_r);
    assign {p_ov_s, p_inc_s} = sat_inc(pc_r);

    // Edge-detect register; resets high so an initially high line produces no rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_d_r <= 1'b1;
        end else if (clear || edge_en_s) begin
            pulse_d_r <= pulse_s;
        end else begin
            pulse_d_r <= 1'b1;
        end
    end

    // Measurement FSM next-state and counter update
    always_comb begin
        state_s = state_r;
        hc_s    = hc_r;
        pc_s    = pc_r;
        msat_s  = msat_r;
        close_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s = ST_HIGH;
                    hc_s    = CNT_ONE;
                    pc_s    = CNT_ONE;
                    msat_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                pc_s = p_inc_s;
                if (pulse_s) begin
                    hc_s   = h_inc_s;
                    msat_s = msat_r | p_ov_s | h_ov_s;
                end else begin
                    msat_s = msat_r | p_ov_s;
                end
                if (fall_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    close_s = 1'b1;
                    state_s = ST_HIGH;
                    hc_s    = CNT_ONE;
                    pc_s    = CNT_ONE;
                    msat_s  = 1'b0;
                end else begin
                    pc_s    = p_inc_s;
                    msat_s  = msat_r | p_ov_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                hc_s    = CNT_ZERO;
                pc_s    = CNT_ZERO;
                msat_s  = 1'b0;
            end
        endcase
    end

    // FSM state and counter registers; clear abandons any partial measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            hc_r    <= CNT_ZERO;
            pc_r    <= CNT_ZERO;
            msat_r  <= 1'b0;
        end else if (clear) begin
            state_r <= ST_IDLE;
            hc_r    <= CNT_ZERO;
            pc_r    <= CNT_ZERO;
            msat_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            hc_r    <= hc_s;
            pc_r    <= pc_s;
            msat_r  <= msat_r == msat_s ? msat_r : msat_s;
        end
    end

    // One-entry holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            high_cnt   <= CNT_ZERO;
            period_cnt <= CNT_ZERO;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            meas_valid <= 1'b0;
            high_cnt   <= CNT_ZERO;
            period_cnt <= CNT_ZERO;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else if (close_s && (!meas_valid || meas_ready)) begin
            meas_valid <= 1'b1;
            high_cnt   <= hc_r;
            period_cnt <= pc_r;
            sat        <= msat_r;
        end else begin
            if (close_s) begin
                overrun <= 1'b1;
            end
            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
        end
    end

endmodule
